// File: rtl/spi_resp_tx.sv
// SPI responder: shifts a FRAME_BITS frame MSB-first on miso from an oversampled SCLK/SS.
// Latency: pin edge to strobe SYNC_STAGES+1 clk; miso/miso_oe/pulses one clk later.
// Backpressure: none; the master paces the frame and a load during a frame applies to the next frame.
module spi_resp_tx #(
    parameter  int FRAME_BITS  = 40,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = $clog2(FRAME_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_in,
    input  logic                  ss_in,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [CW-1:0]         bit_cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sclk_sync, ss_sync;
    logic                    sclk_d, ss_d;
    logic [SYNC_STAGES:0]    flush;
    logic                    armed;
    logic                    ss_ok;
    logic                    sclk_s, ss_s;
    logic                    sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                    start, finish;
    logic [FRAME_BITS-1:0]   hold;
    // Holds only the bits still to be sent; the bit currently on miso lives in the miso flop.
    logic [FRAME_BITS-2:0]   sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            flush     <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
            flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
            armed     <= ss_ok;
        end
    end

    // The SS chain resets to idle-high, so a pin already low at reset release would look like a
    // falling edge; frames are only accepted once a genuine high level has come through the chain.
    assign ss_ok     = armed | (flush[SYNC_STAGES] & ss_d);
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d & ss_ok;
    assign ss_rise   = ss_s & ~ss_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (ss_fall) begin
                state_nxt = SHIFT;
                start     = 1'b1;
            end
            SHIFT: if (ss_rise) begin
                state_nxt = IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold        <= '0;
            sr          <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (tx_load) hold <= tx_data;
            if (start) begin
                sr      <= hold[FRAME_BITS-2:0];
                miso    <= hold[FRAME_BITS-1];
                miso_oe <= 1'b1;
                bit_cnt <= '0;
            end else if (finish) begin
                miso        <= 1'b0;
                miso_oe     <= 1'b0;
                frame_done  <= (bit_cnt == CNT_MAX);
                frame_abort <= (bit_cnt != CNT_MAX);
            end else if (state == SHIFT) begin
                if (sclk_rise && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                if (sclk_fall) begin
                    miso <= sr[FRAME_BITS-2];
                    sr   <= {sr[FRAME_BITS-3:0], 1'b0};
                end
            end
        end
    end

    assign tx_busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_resp_tx.sv
// Bench for spi_resp_tx: directed frames from the test plan plus randomized frames vs a frame-level model.
module tb_spi_resp_tx;

    localparam int FB = 40;
    localparam int SS = 2;
    localparam int CW = $clog2(FB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk_in;
    logic          ss_in;
    logic          miso;
    logic          miso_oe;
    logic [FB-1:0] tx_data;
    logic          tx_load;
    logic          tx_busy;
    logic          frame_done;
    logic          frame_abort;
    logic [CW-1:0] bit_cnt;

    int            assert_cnt = 0;
    int            fail_cnt   = 0;
    int            done_cnt   = 0;
    int            abort_cnt  = 0;
    logic [FB-1:0] hold_m;

    spi_resp_tx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_in     (sclk_in),
        .ss_in       (ss_in),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .bit_cnt     (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [FB-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        hold_m  = d;
    endtask

    // ld_mode: 0 none, 1 load in the middle of the frame, 2 load coincident with the internal SS fall
    task automatic frame_check(input string tag, input int nbits, input int ld_mode,
                               input logic [FB-1:0] ld_d);
        logic [63:0]   rx;
        logic [63:0]   exp;
        logic [FB-1:0] frame_m;
        int            d0, a0, exp_cnt;
        rx      = '0;
        exp     = '0;
        frame_m = hold_m;
        d0      = done_cnt;
        a0      = abort_cnt;
        @(negedge clk);
        ss_in = 1'b0;
        if (ld_mode == 2) begin
            repeat (SS) @(posedge clk);
            @(negedge clk);
            tx_data = ld_d;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            hold_m  = ld_d;
            repeat (6) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        chk({tag, "_oe_on"}, 64'(miso_oe), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            rx      = {rx[62:0], miso};
            sclk_in = 1'b1;
            repeat (6) @(negedge clk);
            sclk_in = 1'b0;
            if (ld_mode == 1 && i == nbits / 2) begin
                @(negedge clk);
                tx_data = ld_d;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                hold_m  = ld_d;
                repeat (4) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
            end
        end
        ss_in = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= nbits; i++)
            exp = {exp[62:0], (i <= FB) ? frame_m[FB-i] : 1'b0};
        exp_cnt = (nbits < FB) ? nbits : FB;
        chk({tag, "_data"}, rx, exp);
        chk({tag, "_bitcnt"}, 64'(bit_cnt), 64'(exp_cnt));
        chk({tag, "_done"}, 64'(done_cnt - d0), (nbits >= FB) ? 64'd1 : 64'd0);
        chk({tag, "_abort"}, 64'(abort_cnt - a0), (nbits >= FB) ? 64'd0 : 64'd1);
        chk({tag, "_oe_off"}, {62'd0, miso_oe, miso}, 64'd0);
    endtask

    initial begin
        int d0, a0, n, mode;
        rst     = 1'b0;
        sclk_in = 1'b0;
        ss_in   = 1'b1;
        tx_data = '0;
        tx_load = 1'b0;
        hold_m  = '0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_oe", 64'(miso_oe), 64'd0);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_abort", 64'(frame_abort), 64'd0);
        chk("rst_bitcnt", 64'(bit_cnt), 64'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        load(40'hA5_3C_0F_F0_81);
        frame_check("basic", 40, 0, '0);

        load(40'h1);
        frame_check("b2b_1", 40, 1, 40'hFF_FFFF_FFFF);
        frame_check("b2b_2", 40, 0, '0);

        load(40'h5A_F00D_1234);
        frame_check("abort", 17, 0, '0);
        frame_check("after_abort", 40, 0, '0);

        load(40'hFF_FFFF_FFFF);
        frame_check("overrun", 44, 0, '0);

        load(40'hDE_ADBE_EF01);
        @(negedge clk);
        ss_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            sclk_in = 1'b1;
            repeat (6) @(negedge clk);
            sclk_in = 1'b0;
            repeat (6) @(negedge clk);
        end
        d0  = done_cnt;
        a0  = abort_cnt;
        rst = 1'b0;
        #1;
        chk("midrst_now", {61'd0, tx_busy, miso_oe, miso}, 64'd0);
        hold_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sclk_in = 1'b1;
            repeat (6) @(negedge clk);
            sclk_in = 1'b0;
            repeat (6) @(negedge clk);
        end
        chk("midrst_noframe", {61'd0, tx_busy, miso_oe, miso}, 64'd0);
        ss_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_nopulse", 64'((done_cnt - d0) + (abort_cnt - a0)), 64'd0);
        frame_check("after_rst", 40, 0, '0);

        load(40'hCA_FE00_0001);
        frame_check("collide_1", 40, 2, 40'h12_3456_789A);
        frame_check("collide_2", 40, 0, '0);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1)
                load({$urandom_range(0, 255), $urandom()});
            n    = $urandom_range(0, 44);
            mode = (n > 0) ? $urandom_range(0, 2) : 0;
            frame_check("rand", n, mode, {$urandom_range(0, 255), $urandom()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
